// File: rtl/call_return_detect.sv
// call_return_detect: fetch-stage predecode in front of the return address stack.
// Scans each accepted instruction for calls and returns, drives the stack push/pop,
// and issues a registered one-cycle fetch redirect on JAL calls and predicted returns.
// After a redirect, the stage drops SQUASH_CYCLES cycles of wrong-path fetch.
// Optional feature: define COMPRESSED_EN to decode RVC C.JAL / C.JALR / C.JR.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   IN_valid/IN_pc/IN_instr  fetched instruction (pc in halfword units)
//   OUT_ready                stage can accept IN_valid this cycle (comb)
//   IN_stall                 decode cannot take OUT_valid this cycle
//   IN_flush                 backend flush, kills all state
//   OUT_valid/OUT_pc/OUT_instr  registered instruction to decode
//   OUT_rsPush/OUT_rsPushData/OUT_rsPop  return stack controls (comb, accept-qualified)
//   IN_rsValid/IN_rsData     return stack non-empty flag and top entry
//   OUT_redirect/OUT_redirectPC  registered fetch redirect pulse and target
module call_return_detect #(
    parameter int unsigned SQUASH_CYCLES = 1,
    parameter int unsigned LINK_ALT      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IN_valid,
    input  logic [30:0] IN_pc,
    input  logic [31:0] IN_instr,
    output logic        OUT_ready,
    input  logic        IN_stall,
    input  logic        IN_flush,
    output logic        OUT_valid,
    output logic [30:0] OUT_pc,
    output logic [31:0] OUT_instr,
    output logic        OUT_rsPush,
    output logic [30:0] OUT_rsPushData,
    output logic        OUT_rsPop,
    input  logic        IN_rsValid,
    input  logic [30:0] IN_rsData,
    output logic        OUT_redirect,
    output logic [30:0] OUT_redirectPC
);

    localparam int unsigned PC_W  = 31;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic {RUN, SQUASH} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic               is_call;
    logic               is_return;
    logic               is_jal_call;
    logic [PC_W-1:0]    jal_target;
    logic [PC_W-1:0]    ret_inc;
    logic               accept;
    logic               redirect_c;
    logic [PC_W-1:0]    redirect_pc_c;

    function automatic logic is_link(input logic [REG_W-1:0] r);
        return (r == REG_W'(1)) || (r == REG_W'(LINK_ALT));
    endfunction

    // Instruction classification (call / return / JAL target)
    always_comb begin
        is_call     = 1'b0;
        is_return   = 1'b0;
        is_jal_call = 1'b0;
        jal_target  = '0;
        ret_inc     = PC_W'(2);

        // JAL offset is already in halfwords: imm[20:1] sign-extended
        jal_target = IN_pc + {{11{IN_instr[31]}}, IN_instr[31], IN_instr[19:12],
                              IN_instr[20], IN_instr[30:21]};

        if (IN_instr[6:0] == OP_JAL && is_link(IN_instr[11:7])) begin
            is_call     = 1'b1;
            is_jal_call = 1'b1;
        end
        if (IN_instr[6:0] == OP_JALR && IN_instr[14:12] == 3'b000) begin
            // A link rd always means call; coroutine swaps (rd and rs1 both link) push only
            if (is_link(IN_instr[11:7])) begin
                is_call = 1'b1;
            end else if (IN_instr[11:7] == '0 && is_link(IN_instr[19:15])
                         && IN_instr[31:20] == '0) begin
                is_return = 1'b1;
            end
        end

`ifdef COMPRESSED_EN
        if (IN_instr[1:0] != 2'b11) begin
            ret_inc = PC_W'(1);
            // C.JAL (RV32): implicit rd=x1
            if (IN_instr[15:13] == 3'b001 && IN_instr[1:0] == 2'b01) begin
                is_call     = 1'b1;
                is_jal_call = 1'b1;
                jal_target  = IN_pc + {{20{IN_instr[12]}}, IN_instr[12], IN_instr[8],
                                       IN_instr[10:9], IN_instr[6], IN_instr[7],
                                       IN_instr[2], IN_instr[11], IN_instr[5:3]};
            end
            // C.JALR: implicit rd=x1, never redirects
            if (IN_instr[15:12] == 4'b1001 && IN_instr[11:7] != '0
                && IN_instr[6:2] == '0 && IN_instr[1:0] == 2'b10) begin
                is_call = 1'b1;
            end
            // C.JR through a link register is a return
            if (IN_instr[15:12] == 4'b1000 && is_link(IN_instr[11:7])
                && IN_instr[6:2] == '0 && IN_instr[1:0] == 2'b10) begin
                is_return = 1'b1;
            end
        end
`endif
    end

    // Handshake and return-stack controls
    assign OUT_ready      = ~OUT_valid | ~IN_stall;
    assign accept         = rst & IN_valid & OUT_ready & ~IN_flush & (state == RUN);
    assign OUT_rsPush     = accept & is_call;
    assign OUT_rsPop      = accept & is_return & IN_rsValid;
    assign OUT_rsPushData = IN_pc + ret_inc;
    assign redirect_c     = accept & (is_jal_call | (is_return & IN_rsValid));
    assign redirect_pc_c  = is_return ? IN_rsData : jal_target;

    // Squash FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Squash FSM next state; counter keeps running through decode stalls
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (IN_flush) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_c) begin
                        state_d = SQUASH;
                        cnt_d   = '0;
                    end
                end
                SQUASH: begin
                    if (cnt == CNT_W'(SQUASH_CYCLES - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output stage to decode and redirect pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            OUT_valid      <= 1'b0;
            OUT_pc         <= '0;
            OUT_instr      <= '0;
            OUT_redirect   <= 1'b0;
            OUT_redirectPC <= '0;
        end else if (IN_flush) begin
            OUT_valid    <= 1'b0;
            OUT_redirect <= 1'b0;
        end else begin
            if (accept) begin
                OUT_valid <= 1'b1;
                OUT_pc    <= IN_pc;
                OUT_instr <= IN_instr;
            end else if (OUT_ready) begin
                OUT_valid <= 1'b0;
            end
            OUT_redirect <= redirect_c;
            if (redirect_c) begin
                OUT_redirectPC <= redirect_pc_c;
            end
        end
    end

endmodule

// File: tb/tb_call_return_detect.sv
// tb_call_return_detect: directed self-checking bench for call_return_detect
// (default parameters: SQUASH_CYCLES=1, LINK_ALT=5).
module tb_call_return_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        IN_valid;
    logic [30:0] IN_pc;
    logic [31:0] IN_instr;
    logic        OUT_ready;
    logic        IN_stall;
    logic        IN_flush;
    logic        OUT_valid;
    logic [30:0] OUT_pc;
    logic [31:0] OUT_instr;
    logic        OUT_rsPush;
    logic [30:0] OUT_rsPushData;
    logic        OUT_rsPop;
    logic        IN_rsValid;
    logic [30:0] IN_rsData;
    logic        OUT_redirect;
    logic [30:0] OUT_redirectPC;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_JAL_RA_100  = 32'h100000EF; // jal x1,+0x100
    localparam logic [31:0] I_RET         = 32'h00008067; // jalr x0,0(x1)
    localparam logic [31:0] I_JALR_RA_T0  = 32'h000280E7; // jalr x1,0(x5)
    localparam logic [31:0] I_JALR_T0_RA  = 32'h000082E7; // jalr x5,0(x1)
    localparam logic [31:0] I_JAL_T0_M4   = 32'hFFDFF2EF; // jal x5,-4
    localparam logic [31:0] I_J_0         = 32'h0000006F; // jal x0,0
    localparam logic [31:0] I_NOP         = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] I_C_JALR_RA   = 32'h00009082; // c.jalr x1

    call_return_detect dut (
        .clk            (clk),
        .rst            (rst),
        .IN_valid       (IN_valid),
        .IN_pc          (IN_pc),
        .IN_instr       (IN_instr),
        .OUT_ready      (OUT_ready),
        .IN_stall       (IN_stall),
        .IN_flush       (IN_flush),
        .OUT_valid      (OUT_valid),
        .OUT_pc         (OUT_pc),
        .OUT_instr      (OUT_instr),
        .OUT_rsPush     (OUT_rsPush),
        .OUT_rsPushData (OUT_rsPushData),
        .OUT_rsPop      (OUT_rsPop),
        .IN_rsValid     (IN_rsValid),
        .IN_rsData      (IN_rsData),
        .OUT_redirect   (OUT_redirect),
        .OUT_redirectPC (OUT_redirectPC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [30:0] pc, input logic [31:0] instr);
        IN_valid = v;
        IN_pc    = pc;
        IN_instr = instr;
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        IN_stall   = 1'b0;
        IN_flush   = 1'b0;
        IN_rsValid = 1'b0;
        IN_rsData  = '0;
        drive(1'b1, 31'h400, I_JAL_RA_100);

        // Reset state, and no push while held in reset
        tick();
        tick();
        chk("rst_valid", 32'(OUT_valid), 32'h0);
        chk("rst_redir", 32'(OUT_redirect), 32'h0);
        chk("rst_redir_pc", 32'(OUT_redirectPC), 32'h0);
        chk("rst_pc", 32'(OUT_pc), 32'h0);
        chk("rst_instr", OUT_instr, 32'h0);
        chk("rst_push", 32'(OUT_rsPush), 32'h0);
        chk("rst_pop", 32'(OUT_rsPop), 32'h0);

        rst = 1'b1;
        drive(1'b0, '0, I_NOP);
        tick();

        // JAL x1,+0x100 at 0x400: push 0x402, redirect 0x480
        drive(1'b1, 31'h400, I_JAL_RA_100);
        chk("jal_ready", 32'(OUT_ready), 32'h1);
        chk("jal_push", 32'(OUT_rsPush), 32'h1);
        chk("jal_push_data", 32'(OUT_rsPushData), 32'h402);
        chk("jal_pop", 32'(OUT_rsPop), 32'h0);
        tick();
        chk("jal_valid", 32'(OUT_valid), 32'h1);
        chk("jal_out_pc", 32'(OUT_pc), 32'h400);
        chk("jal_out_instr", OUT_instr, I_JAL_RA_100);
        chk("jal_redir", 32'(OUT_redirect), 32'h1);
        chk("jal_redir_pc", 32'(OUT_redirectPC), 32'h480);
        // wrong-path fetch is squashed
        drive(1'b1, 31'h402, I_JAL_RA_100);
        chk("sq_push", 32'(OUT_rsPush), 32'h0);
        tick();
        chk("sq_valid", 32'(OUT_valid), 32'h0);
        chk("sq_redir", 32'(OUT_redirect), 32'h0);

        // Return with stack valid: pop and redirect to stack top
        IN_rsValid = 1'b1;
        IN_rsData  = 31'h402;
        drive(1'b1, 31'h500, I_RET);
        chk("ret_pop", 32'(OUT_rsPop), 32'h1);
        chk("ret_push", 32'(OUT_rsPush), 32'h0);
        tick();
        chk("ret_redir", 32'(OUT_redirect), 32'h1);
        chk("ret_redir_pc", 32'(OUT_redirectPC), 32'h402);
        chk("ret_valid", 32'(OUT_valid), 32'h1);
        chk("ret_out_pc", 32'(OUT_pc), 32'h500);
        drive(1'b0, '0, I_NOP);
        tick();
        chk("ret_redir_pulse", 32'(OUT_redirect), 32'h0);

        // Return with empty stack: no pop, no redirect, passes through
        IN_rsValid = 1'b0;
        drive(1'b1, 31'h500, I_RET);
        chk("ret_empty_pop", 32'(OUT_rsPop), 32'h0);
        tick();
        chk("ret_empty_valid", 32'(OUT_valid), 32'h1);
        chk("ret_empty_redir", 32'(OUT_redirect), 32'h0);
        // no squash after a non-redirect: next instruction taken at once
        drive(1'b1, 31'h504, I_NOP);
        chk("nop_ready", 32'(OUT_ready), 32'h1);
        chk("nop_push", 32'(OUT_rsPush), 32'h0);
        tick();
        chk("nop_out_pc", 32'(OUT_pc), 32'h504);

        // JALR call under a 3-cycle stall: no push until the stall drops
        IN_stall = 1'b1;
        drive(1'b1, 31'h600, I_JALR_RA_T0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", 32'(OUT_ready), 32'h0);
            chk("stall_push", 32'(OUT_rsPush), 32'h0);
            tick();
            chk("stall_valid", 32'(OUT_valid), 32'h1);
            chk("stall_out_pc", 32'(OUT_pc), 32'h504);
            chk("stall_out_instr", OUT_instr, I_NOP);
        end
        IN_stall = 1'b0;
        #1;
        chk("unstall_push", 32'(OUT_rsPush), 32'h1);
        chk("unstall_push_data", 32'(OUT_rsPushData), 32'h602);
        tick();
        chk("unstall_out_pc", 32'(OUT_pc), 32'h600);
        chk("jalr_no_redir", 32'(OUT_redirect), 32'h0);

        // Coroutine jalr x5,0(x1): push only
        IN_rsValid = 1'b1;
        drive(1'b1, 31'h700, I_JALR_T0_RA);
        chk("coro_push", 32'(OUT_rsPush), 32'h1);
        chk("coro_pop", 32'(OUT_rsPop), 32'h0);
        chk("coro_push_data", 32'(OUT_rsPushData), 32'h702);
        tick();
        chk("coro_redir", 32'(OUT_redirect), 32'h0);

        // JAL x5,-4 at 0x600 (LINK_ALT, backward target)
        drive(1'b1, 31'h600, I_JAL_T0_M4);
        chk("jalx5_push", 32'(OUT_rsPush), 32'h1);
        tick();
        chk("jalx5_redir", 32'(OUT_redirect), 32'h1);
        chk("jalx5_redir_pc", 32'(OUT_redirectPC), 32'h5FE);

        // Flush during squash: same-cycle input dropped, next cycle clean
        IN_flush = 1'b1;
        drive(1'b1, 31'h5FE, I_JAL_RA_100);
        chk("flush_push", 32'(OUT_rsPush), 32'h0);
        tick();
        chk("flush_valid", 32'(OUT_valid), 32'h0);
        chk("flush_redir", 32'(OUT_redirect), 32'h0);
        IN_flush = 1'b0;
        drive(1'b1, 31'h5FE, I_J_0);
        chk("post_flush_ready", 32'(OUT_ready), 32'h1);
        chk("plain_jump_push", 32'(OUT_rsPush), 32'h0);
        tick();
        chk("post_flush_valid", 32'(OUT_valid), 32'h1);
        chk("post_flush_pc", 32'(OUT_pc), 32'h5FE);
        chk("plain_jump_redir", 32'(OUT_redirect), 32'h0);

        // Address wrap at the top of the 31-bit space
        drive(1'b1, 31'h7FFFFFFF, I_JAL_RA_100);
        chk("wrap_push_data", 32'(OUT_rsPushData), 32'h1);
        tick();
        chk("wrap_redir_pc", 32'(OUT_redirectPC), 32'h7F);
        drive(1'b0, '0, I_NOP);
        tick();

        // C.JALR x1: a call only with compressed decode enabled
        drive(1'b1, 31'h7FFFFFFF, I_C_JALR_RA);
`ifdef COMPRESSED_EN
        chk("cjalr_push", 32'(OUT_rsPush), 32'h1);
        chk("cjalr_push_data", 32'(OUT_rsPushData), 32'h0);
`else
        chk("cjalr_push", 32'(OUT_rsPush), 32'h0);
`endif
        tick();
        chk("cjalr_redir", 32'(OUT_redirect), 32'h0);
        chk("cjalr_valid", 32'(OUT_valid), 32'h1);

        // Mid-operation reset discards the held instruction
        IN_stall = 1'b1;
        rst      = 1'b0;
        drive(1'b1, 31'h400, I_JAL_RA_100);
        chk("midrst_push", 32'(OUT_rsPush), 32'h0);
        tick();
        chk("midrst_valid", 32'(OUT_valid), 32'h0);
        chk("midrst_pc", 32'(OUT_pc), 32'h0);
        rst      = 1'b1;
        IN_stall = 1'b0;
        #1;
        chk("midrst_release_push", 32'(OUT_rsPush), 32'h1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
